fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised instruction-fetch front end: issues sequential word fetches to instruction memory over a
//  valid/ready request channel, buffers responses in an in-order prefetch queue, presents {PC, instr} to
//  decode with valid/ready. Redirect (branch/jump) flushes queue and discards in-flight responses.
//  Sits between imem port and decode; replaces single-register PC fetch.
// PARAMETERS
//  RESET_PC         32'h01000000  PC of first fetch after reset
//  QUEUE_DEPTH      4             prefetch queue entries; power of 2, >= 2
//  MAX_OUTSTANDING  2             max issued-but-unanswered requests; 1..QUEUE_DEPTH
// PORTS
//  clock           in   1   clock
//  reset           in   1   synchronous, active-high reset
//  set_PC          in   1   redirect request
//  new_PC          in   32  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; in request order, no backpressure
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   queue head valid
//  instr_ready     in   1   decode consumes head (deasserted = stall)
//  PC_out          out  32  PC of head instruction
//  instr           out  32  head instruction word
// BEHAVIOUR
//  - Reset (synchronous, active-high, clock): fetch_pc=rsp_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0
//    -> instr_valid=0, imem_req_valid=0 during reset cycle; memory side is reset alongside (no stale rsp).
//  - Credit rule: imem_req_valid = !set_PC && (count+outstanding) < QUEUE_DEPTH && outstanding < MAX_OUTSTANDING.
//    imem_req_addr = fetch_pc. On req handshake fetch_pc += 4 (mod 2^32, 0xFFFFFFFC -> 0x0); outstanding++.
//  - Response: outstanding-- every rsp_valid cycle. If drop_cnt>0: discard, drop_cnt--. Else push {rsp_pc, data},
//    rsp_pc += 4. Credit rule guarantees queue never overflows; overflow is an assertion failure.
//  - Output: instr_valid = !empty; PC_out/instr = head, combinational from queue storage. Pop on
//    instr_valid && instr_ready. Push into empty queue visible next cycle (1-cycle rsp->decode latency).
//    Push and pop same cycle: count unchanged, order preserved.
//  - Redirect (set_PC=1), priority over everything incl. stall: queue flushed (pop and push ignored),
//    fetch_pc=rsp_pc=new_PC&~3, no request issued that cycle, drop_cnt <= outstanding - rsp_valid
//    (every in-flight request incl. previously-doomed ones is discarded; same-cycle response discarded).
//    First request to new_PC issued next cycle at earliest. Back-to-back set_PC: last target wins.
//  - Counters count/outstanding/drop_cnt sized $clog2(QUEUE_DEPTH+1); outstanding never exceeds MAX_OUTSTANDING.
//  - Reset mid-operation overrides set_PC and all handshakes.
// STRUCTURE
//  - fetch_pkg: fetch_entry_t {arch_reg pc; arch_reg instr;}, FETCH_RESET_PC constant; arch_reg from instructions_pkg.
//  - Sub-module fetch_queue: sync FIFO of fetch_entry_t, params DEPTH; ports push/pop/flush/full/empty/count/head.
//  - Top: fetch_pc/rsp_pc registers, outstanding/drop counters, credit logic.
// TESTING
//  1. Reset released, imem_req_ready=1 -> first req addr 0x01000000; instr_valid=0 until first rsp.
//  2. 1-cycle-latency memory, instr_ready=1 -> PC_out 0x01000000,04,08,0C... in order, no gaps after fill.
//  3. instr_ready=0 for 10 cycles -> count reaches 4, imem_req_valid=0 once count+outstanding=4; release -> order intact.
//  4. 2 requests in flight, set_PC new_PC=0x2000 -> next 2 rsps dropped; first instr_valid has PC_out=0x2000.
//  5. set_PC with instr_ready=0 and rsp_valid=1 same cycle -> queue empty next cycle, that rsp discarded.
//  6. set_PC new_PC=0xFFFFFFFE -> req addrs 0xFFFFFFFC then 0x00000000; PC_out matches.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_prefetch_pkg;

  typedef logic [31:0] arch_reg;

  typedef struct packed {
    arch_reg pc;
    arch_reg instr;
  } fetch_entry_t;

  localparam arch_reg FETCH_RESET_PC = 32'h0100_0000;
  localparam arch_reg PC_STEP        = 32'd4;

  function automatic arch_reg word_align(arch_reg addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Redirect, instruction-memory and decode-side handshake signals of the fetch front end.
interface fetch_prefetch_if;
  import fetch_prefetch_pkg::*;

  logic    set_PC;
  arch_reg new_PC;
  logic    imem_req_valid;
  logic    imem_req_ready;
  arch_reg imem_req_addr;
  logic    imem_rsp_valid;
  arch_reg imem_rsp_data;
  logic    instr_valid;
  logic    instr_ready;
  arch_reg PC_out;
  arch_reg instr;

  modport master (
    input  set_PC, new_PC, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, PC_out, instr
  );

  modport slave (
    output set_PC, new_PC, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, PC_out, instr
  );

endinterface

// File: rtl/fetch_prefetch_queue.sv
// In-order prefetch FIFO of {pc, instr} entries; flush empties it and overrides push/pop.
module fetch_prefetch_queue
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher: credit-limited imem requests, prefetch queue to decode,
// redirect flushes the queue and discards every in-flight response.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter arch_reg     RESET_PC        = FETCH_RESET_PC,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic              clock,
  input logic              reset,
  fetch_prefetch_if.master bus
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0]   DepthLim = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0] OutLim   = CW'(MAX_OUTSTANDING);

  typedef logic [CW-1:0] cnt_t;

  arch_reg      fetch_pc_q, fetch_pc_d;
  arch_reg      rsp_pc_q, rsp_pc_d;
  cnt_t         outstanding_q, outstanding_d;
  cnt_t         drop_cnt_q, drop_cnt_d;
  cnt_t         q_count;
  logic         q_full, q_empty, q_push, q_pop;
  logic         req_fire, rsp_keep;
  logic [CW:0]  credits_used;
  fetch_entry_t q_head, q_in;

  // Queue slots are reserved at request time, so a response can never find the queue full.
  assign credits_used       = {1'b0, q_count} + {1'b0, outstanding_q};
  assign bus.imem_req_valid = !reset && !bus.set_PC && (credits_used < DepthLim)
                              && (outstanding_q < OutLim);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_keep = bus.imem_rsp_valid && (drop_cnt_q == '0);
  assign q_push   = rsp_keep && !bus.set_PC;
  assign q_in     = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};

  assign bus.instr_valid = !reset && !q_empty;
  assign bus.PC_out      = q_head.pc;
  assign bus.instr       = q_head.instr;
  assign q_pop           = bus.instr_valid && bus.instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(bus.imem_rsp_valid);
    if (bus.set_PC) begin
      fetch_pc_d = word_align(bus.new_PC);
      rsp_pc_d   = word_align(bus.new_PC);
      // Everything still in flight belongs to the old stream, including this cycle's response.
      drop_cnt_d = outstanding_q - cnt_t'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (q_push)   rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      assert (!(q_push && q_full)) else $error("fetch queue overflow");
      assert (outstanding_d <= OutLim) else $error("outstanding limit exceeded");
    end
  end

  fetch_prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.set_PC),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model plus an expected-stream model of delivered PCs.
module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  localparam arch_reg RstPc  = 32'h0100_0000;
  localparam int      MaxOut = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_prefetch_if bus ();

  fetch_prefetch #(
    .RESET_PC        (RstPc),
    .QUEUE_DEPTH     (4),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  arch_reg     pend_q[$];
  arch_reg     exp_pc, exp_req;
  bit          prev_redirect;

  function automatic arch_reg mem_word(arch_reg a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, sample once settled, update models for the next edge.
  task automatic cycle(bit rst, bit spc, arch_reg npc, bit rdy, bit mem_rdy, bit rsp_en);
    bit rsp;
    @(negedge clock);
    reset = rst;
    if (rst) pend_q.delete();
    rsp = !rst && rsp_en && (pend_q.size() > 0);
    bus.set_PC         = spc && !rst;
    bus.new_PC         = npc;
    bus.instr_ready    = rdy;
    bus.imem_req_ready = mem_rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend_q[0]) : 32'h0;
    #1;
    if (rst) begin
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      exp_pc        = RstPc;
      exp_req       = RstPc;
      prev_redirect = 1'b0;
      return;
    end
    if (spc) check("redirect_no_req", 32'(bus.imem_req_valid), 32'd0);
    if (prev_redirect) check("flushed_after_redirect", 32'(bus.instr_valid), 32'd0);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_req);
    if (!spc && bus.instr_valid && rdy) begin
      check("pc_out", bus.PC_out, exp_pc);
      check("instr", bus.instr, mem_word(exp_pc));
      exp_pc += 32'd4;
    end
    if (rsp) void'(pend_q.pop_front());
    if (bus.imem_req_valid && mem_rdy) begin
      pend_q.push_back(bus.imem_req_addr);
      exp_req += 32'd4;
    end
    if (spc) begin
      exp_pc  = npc & ~32'h3;
      exp_req = npc & ~32'h3;
    end
    check("outstanding_bound", 32'(pend_q.size() <= MaxOut), 32'd1);
    prev_redirect = spc;
  endtask

  initial begin
    bus.set_PC = 1'b0; bus.new_PC = '0; bus.instr_ready = 1'b0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    exp_pc = RstPc; exp_req = RstPc; prev_redirect = 1'b0;

    repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // First fetch after reset, nothing for decode until the first response has landed.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t1_first_addr", bus.imem_req_addr, 32'h0100_0000);
    check("t1_no_instr", 32'(bus.instr_valid), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t1_rsp_latency", 32'(bus.instr_valid), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t1_first_pc", bus.PC_out, 32'h0100_0000);

    // Streaming with a 1-cycle memory: no bubbles.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      check("t2_no_gap", 32'(bus.instr_valid), 32'd1);
    end

    // Decode stall fills the queue and throttles requests.
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("t3_full_valid", 32'(bus.instr_valid), 32'd1);
    check("t3_req_throttled", 32'(bus.imem_req_valid), 32'd0);
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Redirect with two requests in flight.
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t4_inflight", 32'(pend_q.size()), 32'd2);
    cycle(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t4_valid", 32'(bus.instr_valid), 32'd1);
    check("t4_target_pc", bus.PC_out, 32'h0000_2000);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Redirect during a stall while a response arrives.
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t5_empty", 32'(bus.instr_valid), 32'd0);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Unaligned target near the top of the address space wraps to zero.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t6_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t6_addr_wrap", bus.imem_req_addr, 32'h0000_0000);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Back-to-back redirects: the later target wins.
    cycle(1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of traffic restarts at the reset PC.
    cycle(1'b1, 1'b1, 32'h0000_6000, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("rst_restart_addr", bus.imem_req_addr, RstPc);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
    end
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
